// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the 1-to-4 data-bus router
package bus_pkg;

  localparam int          NUM_TGT   = 4;
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  typedef logic [1:0] tgt_sel_t;

  // One-hot request-valid vector for the selected target.
  function automatic logic [NUM_TGT-1:0] tgt_onehot(input tgt_sel_t s);
    logic [NUM_TGT-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4.sv
// rtl/mux4.sv - 4-input data multiplexer
module mux4 #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] y
);

  // Pure combinational select.
  always_comb begin
    y = d0;
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/bus_demux4.sv
// rtl/bus_demux4.sv - 1-to-4 load/store router, one outstanding transaction; optional watchdog via BUS_TIMEOUT_EN
module bus_demux4
  import bus_pkg::*;
#(
  parameter int                 SEL_LSB        = 28,
  parameter logic [NUM_TGT-1:0] TGT_EN         = 4'b1111,
  parameter int                 TIMEOUT_CYCLES = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_addr,
  input  logic               req_we,
  input  logic [31:0]        req_wdata,
  input  logic [3:0]         req_wstrb,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic [NUM_TGT-1:0] t_req_valid,
  input  logic [NUM_TGT-1:0] t_req_ready,
  output logic [31:0]        t_addr,
  output logic               t_we,
  output logic [31:0]        t_wdata,
  output logic [3:0]         t_wstrb,
  input  logic [NUM_TGT-1:0] t_rsp_valid,
  input  logic [31:0]        t_rsp_rdata0,
  input  logic [31:0]        t_rsp_rdata1,
  input  logic [31:0]        t_rsp_rdata2,
  input  logic [31:0]        t_rsp_rdata3
);

  state_t      state, state_nx;
  tgt_sel_t    sel;
  tgt_sel_t    req_sel;
  logic        accept;
  logic        rsp_hit;
  logic        timeout;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] mux_y;

  assign req_sel = req_addr[SEL_LSB+1:SEL_LSB];
  assign accept  = (state == IDLE) && req_valid;
  // A response counts only from the selected target, and in REQ only together with its ready.
  assign rsp_hit = t_rsp_valid[sel] &&
                   ((state == WAIT) || ((state == REQ) && t_req_ready[sel]));

`ifdef BUS_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDOG_W-1:0] wdog;

  // Watchdog: counts cycles spent in REQ/WAIT, held at zero everywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog <= '0;
    end else if ((state == REQ) || (state == WAIT)) begin
      wdog <= wdog + 1'b1;
    end else begin
      wdog <= '0;
    end
  end

  assign timeout = ((state == REQ) || (state == WAIT)) &&
                   (wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog compiled out: constant false, transactions wait indefinitely.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode; a real response wins over a coincident timeout.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nx = TGT_EN[req_sel] ? REQ : RESP;
        end
      end
      REQ: begin
        if (rsp_hit || timeout) begin
          state_nx = RESP;
        end else if (t_req_ready[sel]) begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (rsp_hit || timeout) begin
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request fields and target select, latched on accept and held until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel     <= '0;
      t_addr  <= '0;
      t_we    <= 1'b0;
      t_wdata <= '0;
      t_wstrb <= '0;
    end else if (accept) begin
      sel     <= req_sel;
      t_addr  <= req_addr;
      t_we    <= req_we;
      t_wdata <= req_wdata;
      t_wstrb <= req_wstrb;
    end
  end

  // Response data/error capture: unmapped error at accept, target data on hit, error on timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (accept) begin
      err_q   <= ~TGT_EN[req_sel];
      rdata_q <= TGT_EN[req_sel] ? 32'h0 : ERR_RDATA;
    end else if (rsp_hit) begin
      err_q   <= 1'b0;
      rdata_q <= t_we ? 32'h0 : mux_y;
    end else if (timeout) begin
      err_q   <= 1'b1;
      rdata_q <= ERR_RDATA;
    end
  end

  mux4 #(.WIDTH(32)) u_rsp_mux (
    .sel (sel),
    .d0  (t_rsp_rdata0),
    .d1  (t_rsp_rdata1),
    .d2  (t_rsp_rdata2),
    .d3  (t_rsp_rdata3),
    .y   (mux_y)
  );

  assign req_ready   = (state == IDLE);
  assign rsp_valid   = (state == RESP);
  assign rsp_rdata   = rsp_valid ? rdata_q : 32'h0;
  assign rsp_err     = rsp_valid & err_q;
  assign t_req_valid = (state == REQ) ? tgt_onehot(sel) : '0;

endmodule

// File: tb/tb_bus_demux4.sv
// tb/tb_bus_demux4.sv - self-checking bench for bus_demux4 (watchdog cases under BUS_TIMEOUT_EN)
module tb_bus_demux4;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [3:0]  t_req_valid;
  logic [3:0]  t_req_ready = '0;
  logic [31:0] t_addr;
  logic        t_we;
  logic [31:0] t_wdata;
  logic [3:0]  t_wstrb;
  logic [3:0]  t_rsp_valid = '0;
  logic [31:0] trd [4];

  int   total = 0;
  int   bad = 0;
  int   pulses = 0;
  exp_t sb [$];

  always #5 clk = ~clk;

  bus_demux4 #(
    .SEL_LSB        (28),
    .TGT_EN         (4'b0111),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_we       (req_we),
    .req_wdata    (req_wdata),
    .req_wstrb    (req_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .t_req_valid  (t_req_valid),
    .t_req_ready  (t_req_ready),
    .t_addr       (t_addr),
    .t_we         (t_we),
    .t_wdata      (t_wdata),
    .t_wstrb      (t_wstrb),
    .t_rsp_valid  (t_rsp_valid),
    .t_rsp_rdata0 (trd[0]),
    .t_rsp_rdata1 (trd[1]),
    .t_rsp_rdata2 (trd[2]),
    .t_rsp_rdata3 (trd[3])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every response pulse pops and compares the oldest expected response.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      pulses++;
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL sb_unexpected observed=rsp_valid expected=no_response");
      end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("sb_rdata", rsp_rdata, e.rdata);
        check("sb_err", {31'h0, rsp_err}, {31'h0, e.err});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction: target tgt=addr[29:28] readies rdy_dly cycles into REQ and responds
  // rsp_dly cycles after that; the next target pulses a stray response on the first cycle.
  task automatic txn(input string tag, input logic [31:0] addr, input logic we,
                     input logic [31:0] wdata, input logic [3:0] wstrb,
                     input int rdy_dly, input int rsp_dly, input bit respond,
                     input logic [31:0] rdata, input int exp_lat, input int exp_vcyc,
                     input logic exp_err, input logic [31:0] exp_rdata);
    int         tgt;
    int         noise;
    int         lat;
    int         vcyc;
    int         unstable;
    logic [3:0] oh;
    tgt      = int'(addr[29:28]);
    noise    = (tgt + 1) % 4;
    oh       = 4'b0001 << tgt;
    lat      = 0;
    vcyc     = 0;
    unstable = 0;
    sb.push_back({exp_err, exp_rdata});
    req_valid = 1'b1;
    req_addr  = addr;
    req_we    = we;
    req_wdata = wdata;
    req_wstrb = wstrb;
    @(negedge clk);
    check({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    tick();
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h0F0F_0F0F;
    req_wstrb = 4'hF;
    req_we    = ~we;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      t_req_ready = '0;
      t_rsp_valid = '0;
      if (n == 1) begin
        t_rsp_valid[noise] = 1'b1;
        trd[noise]         = 32'h5A5A_5A5A;
      end
      if (n == 1 + rdy_dly) t_req_ready[tgt] = 1'b1;
      if (respond && n == 1 + rdy_dly + rsp_dly) begin
        t_rsp_valid[tgt] = 1'b1;
        trd[tgt]         = rdata;
      end
      @(negedge clk);
      if (t_req_valid !== 4'b0000) begin
        vcyc++;
        if (t_req_valid !== oh || t_addr !== addr || t_we !== we ||
            t_wdata !== wdata || t_wstrb !== wstrb) unstable++;
      end
      if (rsp_valid === 1'b1) lat = n;
      tick();
    end
    t_req_ready = '0;
    t_rsp_valid = '0;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_tvalid_cycles"}, 32'(vcyc), 32'(exp_vcyc));
    check({tag, "_fields_stable"}, 32'(unstable), 32'h0);
  endtask

  initial begin
    int p0;
    for (int i = 0; i < 4; i++) trd[i] = 32'h1111_1111 * (i + 1);

    // Reset state
    #2;
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_t_req_valid", {28'h0, t_req_valid}, 32'h0);
    check("rst_t_addr", t_addr, 32'h0);
    check("rst_t_wdata", t_wdata, 32'h0);
    check("rst_t_ctl", {27'h0, t_we, t_wstrb}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // 1. idle for 20 cycles
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_req_ready", {31'h0, req_ready}, 32'h1);
      check("idle_t_req_valid", {28'h0, t_req_valid}, 32'h0);
      check("idle_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    end
    tick();

    // 2. load target 2: ready at once, response one cycle later
    txn("load_t2", 32'h2000_0010, 1'b0, 32'h0, 4'h0, 0, 1, 1'b1, 32'hCAFE_F00D,
        3, 1, 1'b0, 32'hCAFE_F00D);
    // 3. store target 1: ready after 3 cycles, response with ready; store data reads back 0
    txn("store_t1", 32'h1000_0004, 1'b1, 32'h1234_5678, 4'b0011, 3, 0, 1'b1, 32'hFFFF_FFFF,
        5, 4, 1'b0, 32'h0);
    // Minimum latency, back-to-back right after the previous response
    txn("load_t0_min", 32'h0000_0100, 1'b0, 32'h0, 4'h0, 0, 0, 1'b1, 32'h1357_9BDF,
        2, 1, 1'b0, 32'h1357_9BDF);
    // 4. unmapped target 3: error one cycle after accept, no target request
    txn("unmapped_t3", 32'h3000_0000, 1'b0, 32'h0, 4'h0, 0, 0, 1'b0, 32'h0,
        1, 0, 1'b1, 32'hDEAD_BEEF);
    // Another target-2 load with a slow response
    txn("load_t2_slow", 32'h2ABC_0008, 1'b0, 32'h0, 4'h0, 1, 4, 1'b1, 32'h0BAD_F00D,
        7, 2, 1'b0, 32'h0BAD_F00D);

`ifdef BUS_TIMEOUT_EN
    // 5. target 0 accepts, never responds: 16 cycles in REQ/WAIT plus the accept cycle
    txn("timeout_t0", 32'h0000_0200, 1'b0, 32'h0, 4'h0, 0, 0, 1'b0, 32'h0,
        17, 1, 1'b1, 32'hDEAD_BEEF);
    p0 = pulses;
    tick();
    t_rsp_valid[0] = 1'b1;
    trd[0]         = 32'h7777_7777;
    tick();
    t_rsp_valid = '0;
    for (int i = 0; i < 4; i++) tick();
    check("late_rsp_ignored", 32'(pulses - p0), 32'h0);
`endif

    // 6. reset asserted while in WAIT
    p0 = pulses;
    req_valid = 1'b1;
    req_addr  = 32'h0000_0040;
    req_we    = 1'b0;
    tick();
    req_valid      = 1'b0;
    t_req_ready[0] = 1'b1;
    tick();
    t_req_ready = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_req_ready", {31'h0, req_ready}, 32'h1);
    check("midrst_t_req_valid", {28'h0, t_req_valid}, 32'h0);
    check("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("midrst_t_addr", t_addr, 32'h0);
    check("midrst_rsp_rdata", rsp_rdata, 32'h0);
    t_rsp_valid[0] = 1'b1;
    tick();
    t_rsp_valid = '0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("midrst_no_rsp", 32'(pulses - p0), 32'h0);
    txn("after_rst", 32'h2000_0020, 1'b0, 32'h0, 4'h0, 0, 1, 1'b1, 32'hA5A5_0001,
        3, 1, 1'b0, 32'hA5A5_0001);

    tick();
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
